// File: rtl/mips_pkg.sv
// Shared constants for the forwarding pipeline: forward-select codes,
// the hard-wired zero register and the default control-bundle width.
package mips_pkg;
  localparam int CTRL_W = 8;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/idex_operand_stage_if.sv
// ID/EX boundary bus: decoded ID fields and stage write-back buses in,
// registered EX fields, forwarded operands and hazard status out.
interface idex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] id_rd;
  logic [DATA_W-1:0] id_rdata1;
  logic [DATA_W-1:0] id_rdata2;
  logic [DATA_W-1:0] id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_mem_read;
  logic              id_reg_write;
  logic              flush;
  logic              mem_reg_write;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_result;
  logic              stall_id;
  logic              ex_valid;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [ADDR_W-1:0] ex_waddr;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_opa;
  logic [DATA_W-1:0] ex_opb;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_rdata1, id_rdata2,
           id_imm, id_ctrl, id_mem_read, id_reg_write, flush,
           mem_reg_write, mem_waddr, mem_result, wb_reg_write, wb_waddr, wb_result,
    input  stall_id, ex_valid, ex_mem_read, ex_reg_write, ex_waddr, ex_ctrl,
           ex_imm, ex_opa, ex_opb, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_rdata1, id_rdata2,
           id_imm, id_ctrl, id_mem_read, id_reg_write, flush,
           mem_reg_write, mem_waddr, mem_result, wb_reg_write, wb_waddr, wb_result,
    output stall_id, ex_valid, ex_mem_read, ex_reg_write, ex_waddr, ex_ctrl,
           ex_imm, ex_opa, ex_opb, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM result beats MEM/WB result beats the
// latched register data; register 0 never takes a forwarded value.
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] operand,
  output logic [1:0]        sel
);

  // Priority forward select for one operand
  always_comb begin
    operand = reg_data;
    sel     = FWD_REG;
    if (mem_reg_write && (mem_waddr != ADDR_W'(REG_ZERO)) && (mem_waddr == addr)) begin
      operand = mem_result;
      sel     = FWD_MEM;
    end else if (wb_reg_write && (wb_waddr != ADDR_W'(REG_ZERO)) && (wb_waddr == addr)) begin
      operand = wb_result;
      sel     = FWD_WB;
    end else begin
      operand = reg_data;
      sel     = FWD_REG;
    end
  end

endmodule

// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: pipeline register with capture-time WB bypass,
// load-use stall detection, stall counter and 0-cycle EX forwarding.
module idex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = mips_pkg::CTRL_W
) (
  input logic                clk,
  input logic                nrst,
  idex_operand_stage_if.slave bus
);
  import mips_pkg::*;

  logic              ex_valid_r, ex_mem_read_r, ex_reg_write_r;
  logic [ADDR_W-1:0] ex_waddr_r, ex_rs_r, ex_rt_r;
  logic [CTRL_W-1:0] ex_ctrl_r;
  logic [DATA_W-1:0] ex_imm_r, rs_data_r, rt_data_r;
  logic [15:0]       stall_count_r;
  logic              load_use_s;
  logic [DATA_W-1:0] rs_cap_s, rt_cap_s;

  // Load-use hazard against the load currently in EX
  always_comb begin
    load_use_s = 1'b0;
    if (bus.id_valid && ex_valid_r && ex_mem_read_r && (ex_waddr_r != ADDR_W'(REG_ZERO))) begin
      load_use_s = (ex_waddr_r == bus.id_rs) || (bus.id_uses_rt && (ex_waddr_r == bus.id_rt));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Capture data: r0 forced to zero, same-cycle WB write overrides the stale regfile read
  always_comb begin
    rs_cap_s = bus.id_rdata1;
    rt_cap_s = bus.id_rdata2;
    if (bus.id_rs == ADDR_W'(REG_ZERO)) begin
      rs_cap_s = '0;
    end else if (bus.wb_reg_write && (bus.wb_waddr != ADDR_W'(REG_ZERO)) && (bus.wb_waddr == bus.id_rs)) begin
      rs_cap_s = bus.wb_result;
    end else begin
      rs_cap_s = bus.id_rdata1;
    end
    if (bus.id_rt == ADDR_W'(REG_ZERO)) begin
      rt_cap_s = '0;
    end else if (bus.wb_reg_write && (bus.wb_waddr != ADDR_W'(REG_ZERO)) && (bus.wb_waddr == bus.id_rt)) begin
      rt_cap_s = bus.wb_result;
    end else begin
      rt_cap_s = bus.id_rdata2;
    end
  end

  // ID/EX register: reset, then flush/stall bubble, else capture
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ex_valid_r     <= 1'b0;
      ex_mem_read_r  <= 1'b0;
      ex_reg_write_r <= 1'b0;
      ex_waddr_r     <= '0;
      ex_rs_r        <= '0;
      ex_rt_r        <= '0;
      ex_ctrl_r      <= '0;
      ex_imm_r       <= '0;
      rs_data_r      <= '0;
      rt_data_r      <= '0;
    end else if (bus.flush || load_use_s) begin
      ex_valid_r     <= 1'b0;
      ex_mem_read_r  <= 1'b0;
      ex_reg_write_r <= 1'b0;
      ex_ctrl_r      <= '0;
    end else begin
      ex_valid_r     <= bus.id_valid;
      ex_mem_read_r  <= bus.id_mem_read;
      ex_reg_write_r <= bus.id_reg_write;
      ex_waddr_r     <= bus.id_rd;
      ex_rs_r        <= bus.id_rs;
      ex_rt_r        <= bus.id_rt;
      ex_ctrl_r      <= bus.id_ctrl;
      ex_imm_r       <= bus.id_imm;
      rs_data_r      <= rs_cap_s;
      rt_data_r      <= rt_cap_s;
    end
  end

  // Saturating count of stall cycles that were not overridden by a flush
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_count_r <= 16'd0;
    end else if (load_use_s && !bus.flush && (stall_count_r != 16'hFFFF)) begin
      stall_count_r <= stall_count_r + 16'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .addr(ex_rs_r), .reg_data(rs_data_r),
    .mem_reg_write(bus.mem_reg_write), .mem_waddr(bus.mem_waddr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_waddr(bus.wb_waddr), .wb_result(bus.wb_result),
    .operand(bus.ex_opa), .sel(bus.fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .addr(ex_rt_r), .reg_data(rt_data_r),
    .mem_reg_write(bus.mem_reg_write), .mem_waddr(bus.mem_waddr), .mem_result(bus.mem_result),
    .wb_reg_write(bus.wb_reg_write), .wb_waddr(bus.wb_waddr), .wb_result(bus.wb_result),
    .operand(bus.ex_opb), .sel(bus.fwd_b)
  );

  assign bus.stall_id     = load_use_s;
  assign bus.ex_valid     = ex_valid_r;
  assign bus.ex_mem_read  = ex_mem_read_r;
  assign bus.ex_reg_write = ex_reg_write_r;
  assign bus.ex_waddr     = ex_waddr_r;
  assign bus.ex_ctrl      = ex_ctrl_r;
  assign bus.ex_imm       = ex_imm_r;
  assign bus.stall_count  = stall_count_r;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboard bench for idex_operand_stage: directed hazard/forwarding scenarios
// plus randomized traffic checked against a transaction-level reference model.
module tb_idex_operand_stage;

  logic clk;
  logic nrst;

  idex_operand_stage_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(8)) bus ();

  idex_operand_stage dut (.clk(clk), .nrst(nrst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural content of the EX slot as the model sees it
  typedef struct packed {
    bit        valid, mem_read, reg_write, clean;
    bit [4:0]  waddr, rs, rt;
    bit [7:0]  ctrl;
    bit [31:0] imm, d1, d2;
  } ex_t;

  typedef struct packed {
    bit        stall, valid, mem_read, reg_write, full;
    bit [15:0] cnt;
    bit [7:0]  ctrl;
    bit [4:0]  waddr;
    bit [31:0] imm, opa, opb;
    bit [1:0]  fa, fb;
  } exp_t;

  ex_t       m;
  bit [15:0] m_cnt;
  exp_t      q[$];
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Operand seen by the ALU: newest in-flight writer of that register wins
  function automatic void resolve(input bit [4:0] a, input bit [31:0] d,
                                  output bit [31:0] v, output bit [1:0] s);
    if (a != 5'd0 && bus.mem_reg_write && bus.mem_waddr == a) begin
      v = bus.mem_result; s = 2'b10;
    end else if (a != 5'd0 && bus.wb_reg_write && bus.wb_waddr == a) begin
      v = bus.wb_result; s = 2'b01;
    end else begin
      v = d; s = 2'b00;
    end
  endfunction

  // Register value delivered at capture: r0 is zero, a WB write this cycle is newer than the read
  function automatic bit [31:0] reg_value(input bit [4:0] a, input bit [31:0] rdata);
    if (a == 5'd0) return 32'd0;
    if (bus.wb_reg_write && bus.wb_waddr == a) return bus.wb_result;
    return rdata;
  endfunction

  task automatic clr();
    bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.id_rd = 5'd0; bus.id_rdata1 = 32'd0; bus.id_rdata2 = 32'd0; bus.id_imm = 32'd0;
    bus.id_ctrl = 8'd0; bus.id_mem_read = 1'b0; bus.id_reg_write = 1'b0; bus.flush = 1'b0;
    bus.mem_reg_write = 1'b0; bus.mem_waddr = 5'd0; bus.mem_result = 32'd0;
    bus.wb_reg_write = 1'b0; bus.wb_waddr = 5'd0; bus.wb_result = 32'd0;
  endtask

  task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit urt, input bit [4:0] rd,
                        input bit [31:0] d1, input bit [31:0] d2, input bit mr, input bit rw);
    bus.id_valid = 1'b1; bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = urt; bus.id_rd = rd;
    bus.id_rdata1 = d1; bus.id_rdata2 = d2; bus.id_mem_read = mr; bus.id_reg_write = rw;
    bus.id_imm = $urandom; bus.id_ctrl = 8'($urandom_range(1, 255));
  endtask

  task automatic set_mem(input bit w, input bit [4:0] a, input bit [31:0] r);
    bus.mem_reg_write = w; bus.mem_waddr = a; bus.mem_result = r;
  endtask

  task automatic set_wb(input bit w, input bit [4:0] a, input bit [31:0] r);
    bus.wb_reg_write = w; bus.wb_waddr = a; bus.wb_result = r;
  endtask

  // Called at a negedge with inputs applied: predict this cycle, advance model across posedge
  task automatic step();
    exp_t e;
    bit   hz;
    #1;
    hz = bus.id_valid && m.valid && m.mem_read && m.waddr != 5'd0 &&
         (m.waddr == bus.id_rs || (bus.id_uses_rt && m.waddr == bus.id_rt));
    e.stall = hz; e.cnt = m_cnt; e.valid = m.valid; e.mem_read = m.mem_read;
    e.reg_write = m.reg_write; e.ctrl = m.ctrl; e.full = m.valid || m.clean;
    e.waddr = m.waddr; e.imm = m.imm;
    resolve(m.rs, m.d1, e.opa, e.fa);
    resolve(m.rt, m.d2, e.opb, e.fb);
    q.push_back(e);
    if (!nrst) begin
      m = '0; m.clean = 1'b1; m_cnt = 16'd0;
    end else begin
      if (hz && !bus.flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (bus.flush || hz) begin
        m.valid = 1'b0; m.mem_read = 1'b0; m.reg_write = 1'b0; m.ctrl = 8'd0;
      end else begin
        m.valid = bus.id_valid; m.mem_read = bus.id_mem_read; m.reg_write = bus.id_reg_write;
        m.waddr = bus.id_rd; m.rs = bus.id_rs; m.rt = bus.id_rt; m.ctrl = bus.id_ctrl;
        m.imm = bus.id_imm; m.clean = 1'b0;
        m.d1 = reg_value(bus.id_rs, bus.id_rdata1);
        m.d2 = reg_value(bus.id_rt, bus.id_rdata2);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: pop the prediction for this cycle and compare what the DUT presents
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_id", bus.stall_id, e.stall);
        chk("stall_count", bus.stall_count, e.cnt);
        chk("ex_valid", bus.ex_valid, e.valid);
        chk("ex_mem_read", bus.ex_mem_read, e.mem_read);
        chk("ex_reg_write", bus.ex_reg_write, e.reg_write);
        chk("ex_ctrl", bus.ex_ctrl, e.ctrl);
        if (e.full) begin
          chk("ex_waddr", bus.ex_waddr, e.waddr);
          chk("ex_imm", bus.ex_imm, e.imm);
          chk("ex_opa", bus.ex_opa, e.opa);
          chk("ex_opb", bus.ex_opb, e.opb);
          chk("fwd_a", bus.fwd_a, e.fa);
          chk("fwd_b", bus.fwd_b, e.fb);
        end
      end
    end
  end

  initial begin
    nrst = 1'b0;
    clr();
    m = '0; m.clean = 1'b1; m_cnt = 16'd0;
    @(negedge clk);

    // Reset held two cycles, with live-looking ID traffic in the second
    step();
    set_id(5'd5, 5'd5, 1'b1, 5'd5, 32'h55, 32'h55, 1'b1, 1'b1);
    step();
    nrst = 1'b1; clr();
    step();

    // add r3,r1,r2 then a reader of r3 in EX while EX/MEM writes r3
    set_id(5'd1, 5'd2, 1'b1, 5'd3, 32'd1, 32'd2, 1'b0, 1'b1);
    step();
    clr(); set_id(5'd3, 5'd2, 1'b1, 5'd4, 32'd0, 32'd2, 1'b0, 1'b1);
    step();
    clr(); set_mem(1'b1, 5'd3, 32'd3);
    step();

    // Both stages write r4: EX/MEM must win
    clr(); set_id(5'd4, 5'd4, 1'b1, 5'd9, 32'h4, 32'h4, 1'b0, 1'b1);
    step();
    clr(); set_mem(1'b1, 5'd4, 32'h40); set_wb(1'b1, 5'd4, 32'h44);
    step();

    // lw r5 followed by a reader of r5 through rt: one stall, then EX/MEM forward
    clr(); set_id(5'd1, 5'd0, 1'b0, 5'd5, 32'h10, 32'h0, 1'b1, 1'b1);
    step();
    clr(); set_id(5'd2, 5'd5, 1'b1, 5'd6, 32'h20, 32'h5, 1'b0, 1'b1);
    step();
    step();
    clr(); set_mem(1'b1, 5'd5, 32'h55);
    step();

    // Capture while WB writes r6: the stale regfile read must be replaced
    clr(); set_id(5'd6, 5'd0, 1'b0, 5'd7, 32'd6, 32'd0, 1'b0, 1'b1);
    set_wb(1'b1, 5'd6, 32'h66);
    step();
    clr();
    step();

    // lw r7 reading r0; then flush coincides with the load-use stall, r0 writes on the buses
    clr(); set_id(5'd0, 5'd0, 1'b1, 5'd7, 32'h1234, 32'h5678, 1'b1, 1'b1);
    step();
    clr(); set_id(5'd7, 5'd0, 1'b0, 5'd8, 32'h7, 32'h0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    set_mem(1'b1, 5'd0, 32'hDEAD); set_wb(1'b1, 5'd0, 32'hBEEF);
    step();
    clr();
    step();

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 800; i++) begin
      nrst = ($urandom_range(0, 99) != 0);
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), $urandom, $urandom,
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7));
      bus.id_valid = ($urandom_range(0, 9) < 8);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_mem(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      step();
    end

    nrst = 1'b1; clr();
    step();
    step();
    @(negedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
